// File: rtl/hazard_control_unit_pkg.sv
// Shared core types for the hazard control unit: register index and FSM state.
package hazard_control_unit_pkg;

    typedef logic [4:0] reg_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hcu_state_t;

    localparam int unsigned PERF_W = 32;

endpackage

// File: rtl/hazard_control_unit_perf_counter.sv
// 32-bit performance counter with enable and synchronous clear; wraps at all-ones.
module hcu_perf_counter
    import hazard_control_unit_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [PERF_W-1:0] o_count
);

    logic [PERF_W-1:0] count_q;
    logic [PERF_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        count_q <= count_d;
    end

    assign o_count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: memory-wait freeze with timeout, redirect flush,
// load-use stall, plus stall/flush performance counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  reg_t        i_ID_rnum1,
    input  reg_t        i_ID_rnum2,
    input  logic        i_ID_use_rs1,
    input  logic        i_ID_use_rs2,
    input  logic        i_EX_memRead,
    input  reg_t        i_EX_wnum,
    input  logic        i_EX_redirect,
    input  logic        i_MEM_dreq,
    input  logic        i_MEM_dack,
    output logic        o_PC_en,
    output logic        o_IFID_en,
    output logic        o_EXMEM_en,
    output logic        o_IFID_flush,
    output logic        o_IDEX_flush,
    output logic        o_MEMWB_bubble,
    output logic        o_mem_err,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    // The RUN cycle that starts a wait is the first non-ack cycle, so the
    // abort fires when the count is one short of MEM_TIMEOUT-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 2);

    hcu_state_t state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       load_use;
    logic       freeze;
    logic       redirect_act;
    logic       stall_en;

    assign load_use = i_EX_memRead && (i_EX_wnum != '0) &&
                      ((i_ID_use_rs1 && (i_ID_rnum1 == i_EX_wnum)) ||
                       (i_ID_use_rs2 && (i_ID_rnum2 == i_EX_wnum)));

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        freeze         = 1'b0;
        redirect_act   = 1'b0;
        o_PC_en        = 1'b1;
        o_IFID_en      = 1'b1;
        o_EXMEM_en     = 1'b1;
        o_IFID_flush   = 1'b0;
        o_IDEX_flush   = 1'b0;
        o_MEMWB_bubble = 1'b0;
        o_mem_err      = 1'b0;

        case (state_q)
            RUN: begin
                if (i_MEM_dreq && !i_MEM_dack) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (i_MEM_dack) begin
                    state_d = RUN;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    o_mem_err = 1'b1;
                    state_d   = RUN;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = 8'(wait_cnt_q + 8'd1);
                end
            end
            default: state_d = RUN;
        endcase

        if (freeze) begin
            o_PC_en        = 1'b0;
            o_IFID_en      = 1'b0;
            o_EXMEM_en     = 1'b0;
            o_MEMWB_bubble = 1'b1;
        end else if (i_EX_redirect) begin
            redirect_act = 1'b1;
            o_IFID_flush = 1'b1;
            o_IDEX_flush = 1'b1;
        end else if (load_use) begin
            o_PC_en      = 1'b0;
            o_IFID_en    = 1'b0;
            o_IDEX_flush = 1'b1;
        end

        if (i_rst) begin
            state_d        = RUN;
            wait_cnt_d     = '0;
            redirect_act   = 1'b0;
            o_PC_en        = 1'b0;
            o_IFID_en      = 1'b0;
            o_EXMEM_en     = 1'b0;
            o_IFID_flush   = 1'b1;
            o_IDEX_flush   = 1'b1;
            o_MEMWB_bubble = 1'b1;
            o_mem_err      = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        state_q    <= state_d;
        wait_cnt_q <= wait_cnt_d;
    end

    assign stall_en = !o_PC_en && !i_rst;

    hcu_perf_counter u_stall_cnt (
        .i_clk   (i_clk),
        .i_clr   (i_rst),
        .i_en    (stall_en),
        .o_count (o_stall_cycles)
    );

    hcu_perf_counter u_flush_cnt (
        .i_clk   (i_clk),
        .i_clr   (i_rst),
        .i_en    (redirect_act),
        .o_count (o_flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (MEM_TIMEOUT=4).
module tb_hazard_control_unit;
    import hazard_control_unit_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    reg_t        i_ID_rnum1, i_ID_rnum2;
    logic        i_ID_use_rs1, i_ID_use_rs2;
    logic        i_EX_memRead;
    reg_t        i_EX_wnum;
    logic        i_EX_redirect;
    logic        i_MEM_dreq, i_MEM_dack;
    logic        o_PC_en, o_IFID_en, o_EXMEM_en;
    logic        o_IFID_flush, o_IDEX_flush, o_MEMWB_bubble, o_mem_err;
    logic [31:0] o_stall_cycles, o_flush_count;

    int n_assert = 0;
    int n_fail   = 0;

    // {PC_en, IFID_en, EXMEM_en, IFID_flush, IDEX_flush, MEMWB_bubble, mem_err}
    localparam logic [6:0] C_NORMAL  = 7'b111_000_0;
    localparam logic [6:0] C_RESET   = 7'b000_111_0;
    localparam logic [6:0] C_FREEZE  = 7'b000_001_0;
    localparam logic [6:0] C_REDIR   = 7'b111_110_0;
    localparam logic [6:0] C_LDUSE   = 7'b001_010_0;
    localparam logic [6:0] C_TIMEOUT = 7'b111_000_1;

    hazard_control_unit #(.MEM_TIMEOUT(4)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_ID_rnum1     (i_ID_rnum1),
        .i_ID_rnum2     (i_ID_rnum2),
        .i_ID_use_rs1   (i_ID_use_rs1),
        .i_ID_use_rs2   (i_ID_use_rs2),
        .i_EX_memRead   (i_EX_memRead),
        .i_EX_wnum      (i_EX_wnum),
        .i_EX_redirect  (i_EX_redirect),
        .i_MEM_dreq     (i_MEM_dreq),
        .i_MEM_dack     (i_MEM_dack),
        .o_PC_en        (o_PC_en),
        .o_IFID_en      (o_IFID_en),
        .o_EXMEM_en     (o_EXMEM_en),
        .o_IFID_flush   (o_IFID_flush),
        .o_IDEX_flush   (o_IDEX_flush),
        .o_MEMWB_bubble (o_MEMWB_bubble),
        .o_mem_err      (o_mem_err),
        .o_stall_cycles (o_stall_cycles),
        .o_flush_count  (o_flush_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, o_PC_en, o_IFID_en, o_EXMEM_en, o_IFID_flush,
                  o_IDEX_flush, o_MEMWB_bubble, o_mem_err}, {25'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] stall, input logic [31:0] flush);
        chk({tag, "_stall"}, o_stall_cycles, stall);
        chk({tag, "_flush"}, o_flush_count, flush);
    endtask

    // Advance past a rising edge; inputs are driven 2 time units later.
    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic idle();
        i_ID_rnum1 = '0; i_ID_rnum2 = '0; i_ID_use_rs1 = 1'b0; i_ID_use_rs2 = 1'b0;
        i_EX_memRead = 1'b0; i_EX_wnum = '0; i_EX_redirect = 1'b0;
        i_MEM_dreq = 1'b0; i_MEM_dack = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        idle();
        #1;
        chk_ctrl("reset_ctrl", C_RESET);
        tick(); #1;
        chk_cnt("reset", 32'd0, 32'd0);
        chk("reset_state", 32'(dut.state_q), 32'(RUN));

        // First cycle after release evaluates RUN
        tick(); i_rst = 1'b0; #1;
        chk_ctrl("post_reset_normal", C_NORMAL);

        // lw x5 in EX, add x6,x5,x1 in ID
        tick(); i_EX_memRead = 1'b1; i_EX_wnum = 5'd5;
        i_ID_rnum1 = 5'd5; i_ID_use_rs1 = 1'b1; i_ID_rnum2 = 5'd1; i_ID_use_rs2 = 1'b1; #1;
        chk_ctrl("loaduse_rs1", C_LDUSE);
        tick(); i_EX_memRead = 1'b0; #1;
        chk_ctrl("loaduse_one_cycle", C_NORMAL);
        chk_cnt("loaduse", 32'd1, 32'd0);

        // Destination x0 never stalls
        tick(); i_EX_memRead = 1'b1; i_EX_wnum = 5'd0; i_ID_rnum1 = 5'd0; #1;
        chk_ctrl("loaduse_x0", C_NORMAL);

        // rs2 match only counts when rs2 is used
        tick(); i_EX_wnum = 5'd7; i_ID_rnum1 = 5'd3; i_ID_rnum2 = 5'd7; i_ID_use_rs2 = 1'b0; #1;
        chk_ctrl("loaduse_rs2_unused", C_NORMAL);
        tick(); i_ID_use_rs2 = 1'b1; #1;
        chk_ctrl("loaduse_rs2", C_LDUSE);

        // Redirect beats load-use
        tick(); i_EX_redirect = 1'b1; #1;
        chk_ctrl("redirect_over_loaduse", C_REDIR);
        tick(); idle(); #1;
        chk_cnt("redirect", 32'd2, 32'd1);

        // Memory wait: dack low 3 cycles, high on the 4th (also the timeout cycle)
        tick(); i_MEM_dreq = 1'b1; #1;
        chk_ctrl("memwait_c1", C_FREEZE);
        tick(); #1;
        chk_ctrl("memwait_c2", C_FREEZE);
        chk("memwait_state", 32'(dut.state_q), 32'(MEM_WAIT));
        tick(); #1;
        chk_ctrl("memwait_c3", C_FREEZE);
        tick(); i_MEM_dack = 1'b1; #1;
        chk_ctrl("memwait_ack_wins", C_NORMAL);
        tick(); idle(); #1;
        chk("memwait_back_run", 32'(dut.state_q), 32'(RUN));
        chk_cnt("memwait", 32'd5, 32'd1);

        // Timeout: dack never arrives
        tick(); i_MEM_dreq = 1'b1; #1;
        chk_ctrl("timeout_c1", C_FREEZE);
        tick(); #1;
        chk_ctrl("timeout_c2", C_FREEZE);
        tick(); #1;
        chk_ctrl("timeout_c3", C_FREEZE);
        tick(); #1;
        chk_ctrl("timeout_c4", C_TIMEOUT);
        tick(); idle(); #1;
        chk_ctrl("timeout_after", C_NORMAL);
        chk("timeout_state", 32'(dut.state_q), 32'(RUN));
        chk_cnt("timeout", 32'd8, 32'd1);

        // Reset in the 2nd MEM_WAIT cycle aborts silently
        tick(); i_MEM_dreq = 1'b1; i_EX_redirect = 1'b1; #1;
        chk_ctrl("rstwait_c1", C_FREEZE);
        tick(); #1;
        chk_ctrl("rstwait_c2", C_FREEZE);
        tick(); i_rst = 1'b1; #1;
        chk_ctrl("rstwait_reset", C_RESET);
        tick(); i_rst = 1'b0; idle(); #1;
        chk_ctrl("rstwait_after", C_NORMAL);
        chk("rstwait_state", 32'(dut.state_q), 32'(RUN));
        chk_cnt("rstwait", 32'd0, 32'd0);

        // Redirect held through a freeze is acted on in the ack cycle
        tick(); i_MEM_dreq = 1'b1; i_EX_redirect = 1'b1; #1;
        chk_ctrl("heldredir_c1", C_FREEZE);
        tick(); #1;
        chk_ctrl("heldredir_c2", C_FREEZE);
        tick(); i_MEM_dack = 1'b1; #1;
        chk_ctrl("heldredir_release", C_REDIR);
        tick(); idle(); #1;
        chk_cnt("heldredir", 32'd2, 32'd1);

        // Stall counter wrap
        force dut.u_stall_cnt.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.count_q;
        #1;
        chk("wrap_preload", o_stall_cycles, 32'hFFFF_FFFF);
        i_EX_memRead = 1'b1; i_EX_wnum = 5'd9; i_ID_rnum1 = 5'd9; i_ID_use_rs1 = 1'b1; #1;
        chk_ctrl("wrap_stall", C_LDUSE);
        tick(); idle(); #1;
        chk("wrap_zero", o_stall_cycles, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64, meaning max data-memory wait cycles before abort (range 2..255).
REQ-002 SHALL have one clock; reset is synchronous and active-high: ports i_clk and i_rst.
REQ-003 i_clk  in  1  core clock, all state on rising edge.
REQ-004 i_rst  in  1  synchronous active-high reset.
REQ-005 i_ID_rnum1 / i_ID_rnum2  in  reg_t  source registers of instruction in ID.
REQ-006 i_ID_use_rs1 / i_ID_use_rs2  in  1  ID instruction actually reads rs1/rs2.
REQ-007 i_EX_memRead  in  1  instruction in EX is a load; i_EX_wnum  in  reg_t  its destination.
REQ-008 i_EX_redirect  in  1  branch taken / jump resolved in EX.
REQ-009 i_MEM_dreq  in  1  MEM-stage load/store request valid; i_MEM_dack  in  1  data memory done.
REQ-010 o_PC_en, o_IFID_en, o_EXMEM_en  out  1  stage register enables (IDEX enable equals o_EXMEM_en).
REQ-011 o_IFID_flush, o_IDEX_flush, o_MEMWB_bubble  out  1  insert NOP into the named register.
REQ-012 o_mem_err  out  1  one-cycle pulse on memory timeout.
REQ-013 o_stall_cycles, o_flush_count  out  32  performance counters.

Function
REQ-014 SHALL implement FSM states RUN and MEM_WAIT; stage controls combinational from state and inputs, zero added latency.
REQ-015 Mem stall: in RUN, i_MEM_dreq=1 and i_MEM_dack=0 SHALL freeze the pipe (o_PC_en=o_IFID_en=o_EXMEM_en=0, o_MEMWB_bubble=1, flushes 0) and go to MEM_WAIT; dreq with dack in the same cycle SHALL not stall.
REQ-016 In MEM_WAIT, freeze SHALL hold while dack=0; in the dack cycle, outputs SHALL equal RUN evaluation (no freeze), next state RUN.
REQ-017 8-bit wait counter SHALL clear on entering MEM_WAIT, increment per non-ack cycle; when it reaches MEM_TIMEOUT-1 without dack: o_mem_err=1 for that cycle, freeze released, next state RUN.
REQ-018 dack and timeout in the same cycle: dack wins, o_mem_err=0.
REQ-019 Redirect (not frozen): o_IFID_flush=1, o_IDEX_flush=1, o_PC_en=1, o_IFID_en=1.
REQ-020 Load-use (not frozen, no redirect): i_EX_memRead=1, i_EX_wnum!=0, and match (rnum1 with use_rs1 or rnum2 with use_rs2) SHALL give o_PC_en=0, o_IFID_en=0, o_IDEX_flush=1 for exactly that cycle.
REQ-021 Priority: mem freeze > redirect > load-use > normal (all enables 1, flushes/bubble 0).
REQ-022 Redirect during freeze SHALL be ignored that cycle; it is acted on when freeze releases (EX held, input persists).
REQ-023 o_stall_cycles SHALL increment each cycle o_PC_en=0 outside reset; o_flush_count increments each redirect-action cycle; both wrap 0xFFFFFFFF->0.

Reset
REQ-024 While i_rst=1: o_PC_en=o_IFID_en=o_EXMEM_en=0, o_IFID_flush=o_IDEX_flush=o_MEMWB_bubble=1, o_mem_err=0.
REQ-025 Reset SHALL load state RUN, wait counter 0, both perf counters 0; reset in MEM_WAIT SHALL abort the wait with no o_mem_err.
REQ-026 First cycle after reset release SHALL evaluate in RUN from current inputs.

Structure
REQ-027 reg_t and state enum hcu_state_t SHALL live in the shared core package; MEM_TIMEOUT default stays a module parameter.
REQ-028 Perf counters SHALL be one sub-module, hcu_perf_counter (32-bit, enable, sync clear), instanced twice.
REQ-029 No other sub-modules; forwarding decisions remain outside this block.

Verification
REQ-030 EX lw x5, ID add x6,x5,x1 (use_rs1) -> one cycle o_PC_en=0, o_IDEX_flush=1, o_stall_cycles +1; same with i_EX_wnum=0 -> no stall.
REQ-031 dreq=1, dack low 3 cycles then high -> freeze 3 cycles, release in ack cycle, state RUN, o_stall_cycles +3.
REQ-032 MEM_TIMEOUT=4, dack never -> freeze 3 cycles, o_mem_err pulse in cycle 4 with freeze released, then RUN.
REQ-033 i_EX_redirect with simultaneous load-use match -> only flushes, o_PC_en=1, o_flush_count +1.
REQ-034 i_rst asserted 2nd cycle of MEM_WAIT -> REQ-024 outputs, counters 0, no o_mem_err; redirect held during freeze acted on in release cycle.
REQ-035 Preload o_stall_cycles 0xFFFFFFFF via force, one stall -> counter reads 0.
